// File: rtl/red_pitaya_pwm_sd.sv
// rtl/red_pitaya_pwm_sd.sv - sigma-delta dithered PWM generator with register window
module red_pitaya_pwm_sd #(
    parameter int PERIOD_BITS = 8,
    parameter int DATA_BITS   = 14
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [DATA_BITS-1:0] dat_i,
    output logic                 pwm_o,
    input  logic [15:0]          addr,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ack
);

    // Fraction bits that are dithered across frames; fixed by the two widths.
    localparam int FRAC_BITS = DATA_BITS - PERIOD_BITS;

    localparam logic [15:0] ADDR_CTRL   = 16'h0000;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;
    localparam logic [15:0] ADDR_FRAMES = 16'h0008;

    // Offset-binary conversion constant: flipping the MSB maps signed to unsigned.
    localparam logic [DATA_BITS-1:0] MSB_FLIP = {1'b1, {(DATA_BITS-1){1'b0}}};

    // Frame counter and modulation state
    logic [PERIOD_BITS-1:0] r_cnt;
    logic [FRAC_BITS-1:0]   r_acc;
    logic [PERIOD_BITS:0]   r_duty;
    logic [31:0]            r_frames;
    logic                   r_pwm;

    // Control register
    logic                   r_enable;
    logic                   r_invert;

    // Bus response registers
    logic                   r_ack;
    logic [31:0]            r_rdata;

    // Combinational helpers
    logic                   w_frame_end;
    logic [DATA_BITS-1:0]   w_u;
    logic [PERIOD_BITS-1:0] w_base;
    logic [FRAC_BITS-1:0]   w_frac;
    logic [FRAC_BITS:0]     w_acc_sum;
    logic                   w_carry;
    logic [PERIOD_BITS:0]   w_duty_next;
    logic                   w_active;
    logic                   w_wr_ctrl;
    logic [31:0]            w_rd_val;
    logic                   w_unused_wdata;

    assign w_frame_end = &r_cnt;
    assign w_u         = dat_i ^ MSB_FLIP;
    assign w_base      = w_u[DATA_BITS-1:FRAC_BITS];
    assign w_frac      = w_u[FRAC_BITS-1:0];

    // First-order accumulator: the carry out adds one extra active cycle to this frame.
    assign w_acc_sum   = {1'b0, r_acc} + {1'b0, w_frac};
    assign w_carry     = w_acc_sum[FRAC_BITS];
    assign w_duty_next = {1'b0, w_base} + {{PERIOD_BITS{1'b0}}, w_carry};

    // Duty is 9 bits so a duty of 256 keeps the output active for the whole frame.
    assign w_active    = ({1'b0, r_cnt} < r_duty);

    assign w_wr_ctrl   = wen && (addr == ADDR_CTRL);

    // Only the two control bits of wdata are meaningful.
    assign w_unused_wdata = ^wdata[31:2];

    // Free-running frame counter, independent of enable.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame boundary: sample the input, advance the accumulator and load the new duty.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_acc    <= '0;
            r_duty   <= '0;
            r_frames <= '0;
        end else if (w_frame_end) begin
            r_acc    <= w_acc_sum[FRAC_BITS-1:0];
            r_duty   <= w_duty_next;
            r_frames <= r_frames + 32'd1;
        end
    end

    // Registered PWM output; enable gates after the polarity so disable always yields 0.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= r_enable & (w_active ^ r_invert);
        end
    end

    // Control register write; enable defaults to on so the pin is live out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_enable <= 1'b1;
            r_invert <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_enable <= wdata[0];
            r_invert <= wdata[1];
        end
    end

    // Read mux sees pre-write register values, so a simultaneous write+read returns old data.
    always_comb begin
        w_rd_val = '0;
        case (addr)
            ADDR_CTRL: begin
                w_rd_val[0] = r_enable;
                w_rd_val[1] = r_invert;
            end
            ADDR_STATUS: begin
                w_rd_val[PERIOD_BITS:0]   = r_duty;
                w_rd_val[16 +: FRAC_BITS] = r_acc;
            end
            ADDR_FRAMES: begin
                w_rd_val = r_frames;
            end
            default: begin
                w_rd_val = '0;
            end
        endcase
    end

    // One-cycle bus response: ack follows any strobe, rdata carries the read result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= wen | ren;
            r_rdata <= ren ? w_rd_val : 32'd0;
        end
    end

    assign pwm_o = r_pwm;
    assign ack   = r_ack;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_red_pitaya_pwm_sd.sv
// tb/tb_red_pitaya_pwm_sd.sv - directed self-checking bench for red_pitaya_pwm_sd
module tb_red_pitaya_pwm_sd;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [13:0] dat_i;
    logic        pwm_o;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    int n_pass  = 0;
    int n_total = 0;

    // Reference frame counter: value of the DUT counter as seen at each falling edge.
    logic [7:0] m_cnt;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) m_cnt <= 8'd0;
        else         m_cnt <= m_cnt + 8'd1;
    end

    red_pitaya_pwm_sd dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .dat_i  (dat_i),
        .pwm_o  (pwm_o),
        .addr   (addr),
        .wen    (wen),
        .ren    (ren),
        .wdata  (wdata),
        .rdata  (rdata),
        .ack    (ack)
    );

    // Advance to the next falling edge where the reference counter equals tgt.
    task automatic wait_cnt(input int tgt);
        int g;
        g = 0;
        do begin
            @(negedge clk_i);
            g++;
        end while ((int'(m_cnt) != tgt) && (g < 600));
        if (int'(m_cnt) != tgt) begin
            n_total++;
            $display("FAIL wait_cnt_timeout: cnt %0d required %0d", m_cnt, tgt);
        end
    endtask

    // Collect one PWM frame (256 samples, first sample is the cycle after cnt==0).
    task automatic measure_frame(input int chg_at, input logic [13:0] chg_val,
                                 output int hi, output logic first_hi, output logic last_hi);
        int g;
        g  = 0;
        hi = 0;
        while ((m_cnt != 8'd1) && (g < 600)) begin
            @(negedge clk_i);
            g++;
        end
        if (m_cnt != 8'd1) begin
            n_total++;
            $display("FAIL frame_align_timeout: cnt %0d required 1", m_cnt);
        end
        first_hi = pwm_o;
        last_hi  = pwm_o;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk_i);
            if (int'(m_cnt) == chg_at) dat_i = chg_val;
            if (pwm_o === 1'b1) hi++;
            last_hi = pwm_o;
        end
    endtask

    // Single bus strobe starting at a falling edge; returns rdata/ack and ack one cycle later.
    task automatic bus_xfer(input logic [15:0] a, input logic w, input logic r, input logic [31:0] wd,
                            output logic [31:0] rd, output logic ak, output logic ak_after);
        addr  = a;
        wen   = w;
        ren   = r;
        wdata = wd;
        @(negedge clk_i);
        rd  = rdata;
        ak  = ack;
        wen = 1'b0;
        ren = 1'b0;
        @(negedge clk_i);
        ak_after = ack;
    endtask

    task automatic test_reset;
        int hi; logic fh, lh; logic [31:0] rd; logic ak, ak2;
        rstn_i = 1'b0;
        dat_i  = 14'd0;
        addr   = 16'd0;
        wen    = 1'b0;
        ren    = 1'b0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk_i);
        n_total++; if (pwm_o !== 1'b0) $display("FAIL reset_pwm: got %0b expected 0", pwm_o); else n_pass++;
        n_total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %0b expected 0", ack); else n_pass++;
        n_total++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %0h expected 0", rdata); else n_pass++;
        rstn_i = 1'b1;
        measure_frame(-1, 14'd0, hi, fh, lh);
        n_total++; if (hi !== 0) $display("FAIL reset_frame1_high: got %0d expected 0", hi); else n_pass++;
        bus_xfer(16'h0008, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'd1) $display("FAIL reset_frames_after_1: got %0h expected 1", rd); else n_pass++;
        n_total++; if (ak !== 1'b1) $display("FAIL reset_read_ack: got %0b expected 1", ak); else n_pass++;
    endtask

    task automatic test_zero;
        int hi; logic fh, lh; logic [31:0] rd; logic ak, ak2;
        bus_xfer(16'h0004, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h0000_0080) $display("FAIL zero_status: got %0h expected 80", rd); else n_pass++;
        bus_xfer(16'h0000, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h1) $display("FAIL zero_ctrl_default: got %0h expected 1", rd); else n_pass++;
        measure_frame(-1, 14'd0, hi, fh, lh);
        n_total++; if (hi !== 128) $display("FAIL zero_frame_high: got %0d expected 128", hi); else n_pass++;
        n_total++; if (fh !== 1'b1) $display("FAIL zero_first_sample: got %0b expected 1", fh); else n_pass++;
        n_total++; if (lh !== 1'b0) $display("FAIL zero_last_sample: got %0b expected 0", lh); else n_pass++;
    endtask

    task automatic test_lsb;
        int hi, sum, exp_hi; logic fh, lh; logic [31:0] rd, exp_st; logic ak, ak2;
        wait_cnt(5);
        dat_i = 14'd1;
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            measure_frame(-1, 14'd0, hi, fh, lh);
            sum += hi;
            exp_hi = (k == 63) ? 129 : 128;
            n_total++; if (hi !== exp_hi) $display("FAIL lsb_frame%0d_high: got %0d expected %0d", k, hi, exp_hi); else n_pass++;
        end
        n_total++; if (sum !== 8193) $display("FAIL lsb_sum64: got %0d expected 8193", sum); else n_pass++;
        for (int k = 65; k <= 128; k++) begin
            wait_cnt(10);
            bus_xfer(16'h0004, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
            exp_st = ((k % 64) << 16) | (((k % 64) == 0) ? 129 : 128);
            n_total++; if (rd !== exp_st) $display("FAIL lsb_status_update%0d: got %0h expected %0h", k, rd, exp_st); else n_pass++;
        end
    endtask

    task automatic test_step;
        int hi; logic fh, lh;
        dat_i = 14'd0;
        measure_frame(100, 14'd4096, hi, fh, lh);
        n_total++; if (hi !== 128) $display("FAIL step_current_frame: got %0d expected 128", hi); else n_pass++;
        measure_frame(-1, 14'd0, hi, fh, lh);
        n_total++; if (hi !== 192) $display("FAIL step_next_frame: got %0d expected 192", hi); else n_pass++;
    endtask

    task automatic test_max;
        int hi, sum, n256, n255; logic fh, lh;
        wait_cnt(5);
        dat_i = 14'd8191;
        sum = 0; n256 = 0; n255 = 0;
        for (int k = 0; k < 64; k++) begin
            measure_frame(-1, 14'd0, hi, fh, lh);
            sum += hi;
            if (hi == 256) n256++;
            if (hi == 255) n255++;
        end
        n_total++; if (sum !== 16383) $display("FAIL max_sum64: got %0d expected 16383", sum); else n_pass++;
        n_total++; if (n256 !== 63) $display("FAIL max_full_frames: got %0d expected 63", n256); else n_pass++;
        n_total++; if (n255 !== 1) $display("FAIL max_255_frames: got %0d expected 1", n255); else n_pass++;
    endtask

    task automatic test_min;
        int hi; logic fh, lh; logic [31:0] rd; logic ak, ak2;
        wait_cnt(5);
        dat_i = 14'h2000;
        for (int k = 0; k < 2; k++) begin
            measure_frame(-1, 14'd0, hi, fh, lh);
            n_total++; if (hi !== 0) $display("FAIL min_frame%0d_high: got %0d expected 0", k, hi); else n_pass++;
        end
        bus_xfer(16'h0004, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h003F_0000) $display("FAIL min_status: got %0h expected 3f0000", rd); else n_pass++;
    endtask

    task automatic test_ctrl;
        logic [31:0] rd; logic ak, ak2;
        wait_cnt(5);
        dat_i = 14'd0;
        wait_cnt(1);
        wait_cnt(50);
        n_total++; if (pwm_o !== 1'b1) $display("FAIL ctrl_pre_invert: got %0b expected 1", pwm_o); else n_pass++;
        bus_xfer(16'h0000, 1'b1, 1'b0, 32'h3, rd, ak, ak2);
        n_total++; if (ak !== 1'b1) $display("FAIL ctrl_write_ack: got %0b expected 1", ak); else n_pass++;
        n_total++; if (pwm_o !== 1'b0) $display("FAIL ctrl_inverted_low: got %0b expected 0", pwm_o); else n_pass++;
        wait_cnt(200);
        n_total++; if (pwm_o !== 1'b1) $display("FAIL ctrl_inverted_high: got %0b expected 1", pwm_o); else n_pass++;
        bus_xfer(16'h0000, 1'b1, 1'b0, 32'h2, rd, ak, ak2);
        n_total++; if (pwm_o !== 1'b0) $display("FAIL ctrl_disabled_now: got %0b expected 0", pwm_o); else n_pass++;
        wait_cnt(220);
        n_total++; if (pwm_o !== 1'b0) $display("FAIL ctrl_disabled_later: got %0b expected 0", pwm_o); else n_pass++;
        bus_xfer(16'h0000, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h2) $display("FAIL ctrl_readback: got %0h expected 2", rd); else n_pass++;
        n_total++; if (ak2 !== 1'b0) $display("FAIL ctrl_ack_single: got %0b expected 0", ak2); else n_pass++;
        bus_xfer(16'h000C, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %0h expected 0", rd); else n_pass++;
        n_total++; if (ak !== 1'b1) $display("FAIL unmapped_ack: got %0b expected 1", ak); else n_pass++;
        bus_xfer(16'h0004, 1'b1, 1'b0, 32'hFFFF_FFFF, rd, ak, ak2);
        bus_xfer(16'h000C, 1'b1, 1'b0, 32'hFFFF_FFFF, rd, ak, ak2);
        bus_xfer(16'h0000, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h2) $display("FAIL ro_write_ignored: got %0h expected 2", rd); else n_pass++;
        bus_xfer(16'h0000, 1'b1, 1'b1, 32'h3, rd, ak, ak2);
        n_total++; if (rd !== 32'h2) $display("FAIL wr_rd_prewrite: got %0h expected 2", rd); else n_pass++;
        bus_xfer(16'h0000, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h3) $display("FAIL wr_rd_postwrite: got %0h expected 3", rd); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int hi; logic fh, lh; logic [31:0] rd; logic ak, ak2;
        wait_cnt(200);
        addr = 16'h0008;
        ren  = 1'b1;
        @(posedge clk_i);
        #2;
        n_total++; if (ack !== 1'b1) $display("FAIL rstmid_ack_before: got %0b expected 1", ack); else n_pass++;
        n_total++; if (pwm_o !== 1'b1) $display("FAIL rstmid_pwm_before: got %0b expected 1", pwm_o); else n_pass++;
        rstn_i = 1'b0;
        #1;
        n_total++; if (pwm_o !== 1'b0) $display("FAIL rstmid_pwm_async: got %0b expected 0", pwm_o); else n_pass++;
        n_total++; if (ack !== 1'b0) $display("FAIL rstmid_ack_async: got %0b expected 0", ack); else n_pass++;
        n_total++; if (rdata !== 32'd0) $display("FAIL rstmid_rdata_async: got %0h expected 0", rdata); else n_pass++;
        ren = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        measure_frame(-1, 14'd0, hi, fh, lh);
        n_total++; if (hi !== 0) $display("FAIL rstmid_frame1_high: got %0d expected 0", hi); else n_pass++;
        bus_xfer(16'h0008, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'd1) $display("FAIL rstmid_frames: got %0h expected 1", rd); else n_pass++;
        bus_xfer(16'h0000, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h1) $display("FAIL rstmid_ctrl: got %0h expected 1", rd); else n_pass++;
        bus_xfer(16'h0004, 1'b0, 1'b1, 32'd0, rd, ak, ak2);
        n_total++; if (rd !== 32'h80) $display("FAIL rstmid_status: got %0h expected 80", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_lsb();
        test_step();
        test_max();
        test_min();
        test_ctrl();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/red_pitaya_pwm_sd.md
Name: red_pitaya_pwm_sd

Overview:
Sigma-delta-dithered PWM generator that consumes the DSP router's 14-bit pwm0/pwm1 outputs (one instance per channel) and drives a single slow-DAC PWM pin.
Each 256-cycle PWM frame uses an 8-bit base duty. A first-order accumulator carries the 6 LSBs across frames, so the average over 64 frames equals the full 14-bit code.
It has a small register window on the standard submodule bus (addr/wen/ren/ack/rdata/wdata) for enable, polarity and status readback.

Parameters:
PERIOD_BITS, 8, frame counter width; frame length = 2**PERIOD_BITS clocks
DATA_BITS, 14, input sample width, signed two's complement
FRAC_BITS, 6, DATA_BITS-PERIOD_BITS; dithered fraction width (derived, not overridable)

Ports:
clk_i  in  1  processing clock
rstn_i  in  1  reset; asynchronous, active-low
dat_i  in  14  signed sample from DSP router (pwm0 or pwm1)
pwm_o  out  1  PWM output to pin
addr  in  16  bus address (module-local)
wen  in  1  bus write strobe (pre-qualified by module select)
ren  in  1  bus read strobe (pre-qualified)
wdata  in  32  bus write data
rdata  out  32  bus read data
ack  out  1  bus acknowledge

Behaviour:
- Reset (async assert on rstn_i low, sync release): cnt=0, acc=0, duty=0, frames=0, ctrl.enable=1, ctrl.invert=0, pwm_o=0, ack=0, rdata=0.
- cnt: PERIOD_BITS-bit free-running counter, +1 every clock, wraps 255->0; runs regardless of enable.
- Conversion: u = dat_i + 8192 (flip MSB), unsigned 0..16383; b = u[13:6], f = u[5:0].
- Frame update, only on the clock edge where cnt==255: dat_i sampled; {carry, acc} <= acc + f (7-bit sum); duty <= b + carry (9-bit, range 0..256); frames <= frames+1 (32-bit, wraps). dat_i changes at other cycles have no effect until the next frame boundary.
- New duty is valid from the cycle cnt==0 onward.
- Output: pwm_o <= enable & ((cnt < duty) ^ invert), registered; 1-cycle lag behind cnt.
  - Within each frame pwm_o is active for exactly duty consecutive cycles, starting the cycle after cnt==0.
  - duty=0: never active. duty=256: active the whole frame.
- Sum over any 64 consecutive frames of active cycles = u exactly, when dat_i is constant.
- Accumulator keeps running while disabled; disable forces pwm_o=0 regardless of invert from the next cycle.
- Enable/invert changes take effect on the next clock, mid-frame; no wait for the frame boundary.
- Register map (addr[15:0]):
  - 0x00 ctrl RW: bit0 enable, bit1 invert.
  - 0x04 status RO: duty in [8:0], acc in [21:16].
  - 0x08 frames RO.
  - Other addresses read 0; writes to them and to RO registers are ignored.
- Bus timing: ack <= wen|ren and rdata updated on the same edge, i.e. 1 cycle after the strobe.
  - ack high for one cycle per strobe cycle.
  - wen and ren both high: write performed; rdata returns the pre-write value.
- Reset mid-frame: everything returns to reset values immediately; the first post-reset frame uses duty=0 (pwm_o low for 256 cycles) until the first cnt==255 update.

Test Plan:
- Reset release, dat_i=0: frame 1 pwm_o low 256 cycles; from frame 2, 128 high then 128 low per frame; status reads duty=128, acc=0.
- dat_i=-8192: pwm_o constantly 0. dat_i=8191: over 64 frames, 63 frames fully high (duty=256), one frame duty=255; total high = 16383.
- dat_i=1: duty=128 for 63 frames, then 129 on the 64th frame after loading; acc readback cycles 1,2,...,63,0.
- dat_i stepped 0->4096 at cnt==100: current frame keeps 128 high cycles; next frame 192.
- Write ctrl=0x3 mid-frame with dat_i=0: pwm_o inverted from the next cycle. Write ctrl=0x2: pwm_o=0. Reads of 0x0C: rdata=0 with ack one cycle later.
- Assert rstn_i for 3 cycles mid-frame: pwm_o, ack and frames drop to 0 asynchronously; enable reads back 1 afterwards.
